// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - synchronised, nested-priority interrupt controller with EOI
module irq_controller #(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 2,
  parameter int VEC_W       = 8
) (
  input  logic               clk,
  input  logic               arst,
  input  logic [NUM_IRQ-1:0] irq_req,
  input  logic               irq_en,
  input  logic               masks_wrt,
  input  logic               mode_wrt,
  input  logic [NUM_IRQ-1:0] z_bus_in,
  input  logic               int_vector_wrt,
  input  logic               int_ack,
  input  logic               eoi,
  input  logic               clear_all_ints,
  output logic [NUM_IRQ-1:0] irq_masks,
  output logic [NUM_IRQ-1:0] irq_mode,
  output logic [NUM_IRQ-1:0] irq_status,
  output logic [NUM_IRQ-1:0] irq_in_service,
  output logic [VEC_W-1:0]   irq_vector,
  output logic               int_pending
);

  localparam int IDX_W = $clog2(NUM_IRQ);

  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q;
  logic [NUM_IRQ-1:0] s_cur;
  logic [NUM_IRQ-1:0] s_prev;
  logic [NUM_IRQ-1:0] set_req;
  logic [NUM_IRQ-1:0] ack_hot;
  logic [NUM_IRQ-1:0] below_ceiling;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] status_next;
  logic [NUM_IRQ-1:0] isr_after_eoi;
  logic [NUM_IRQ-1:0] isr_next;
  logic [IDX_W-1:0]   ack_idx;
  logic [IDX_W-1:0]   winner;
  logic [VEC_W-1:0]   vec_next;
  logic               any_eligible;
  logic               blocked;

  assign s_cur   = sync_q[SYNC_STAGES-1];
  assign ack_idx = irq_vector[IDX_W:1];

  // Level channels request every cycle the line is high; edge channels only on a 0->1 step
  assign set_req = s_cur & (irq_mode | ~s_prev);

  // Bring the raw pins into the clock domain and keep one cycle of history for edge detection
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      sync_q <= '0;
      s_prev <= '0;
    end else begin
      if (SYNC_STAGES > 1) begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], irq_req};
      end else begin
        sync_q <= irq_req;
      end
      s_prev <= s_cur;
    end
  end

  // Decode the acknowledged channel, the nesting ceiling and the highest-priority eligible request
  always_comb begin
    ack_hot       = '0;
    below_ceiling = '0;
    blocked       = 1'b0;
    winner        = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (int_ack && (ack_idx == IDX_W'(i))) begin
        ack_hot[i] = 1'b1;
      end
      if (irq_in_service[i]) begin
        blocked = 1'b1;
      end
      below_ceiling[i] = ~blocked;
    end
    eligible = irq_status & irq_masks & below_ceiling;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner = IDX_W'(i);
      end
    end
    any_eligible = |eligible;
  end

  // A new set beats an ack on the same channel so a request arriving during the ack is kept
  assign status_next   = clear_all_ints ? '0 : (set_req | (irq_status & ~ack_hot));
  // EOI retires the highest-priority (lowest index) service level before the ack adds a new one
  assign isr_after_eoi = eoi ? (irq_in_service & (irq_in_service - NUM_IRQ'(1))) : irq_in_service;
  assign isr_next      = clear_all_ints ? '0 : (isr_after_eoi | ack_hot);

  // Vector layout is {zeros, index, 1'b0}
  always_comb begin
    vec_next            = '0;
    vec_next[IDX_W:1]   = winner;
  end

  // Mask and mode registers, written from the Z bus by active-low strobes
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      irq_masks <= '0;
      irq_mode  <= '0;
    end else begin
      if (!masks_wrt) begin
        irq_masks <= z_bus_in;
      end
      if (!mode_wrt) begin
        irq_mode <= z_bus_in;
      end
    end
  end

  // Pending and in-service state
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      irq_status     <= '0;
      irq_in_service <= '0;
    end else begin
      irq_status     <= status_next;
      irq_in_service <= isr_next;
    end
  end

  // Registered request to the sequencer and the vector latch, which holds when nothing is eligible
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      irq_vector  <= '0;
      int_pending <= 1'b0;
    end else begin
      int_pending <= irq_en & any_eligible;
      if (!int_vector_wrt && any_eligible) begin
        irq_vector <= vec_next;
      end
    end
  end

endmodule
